// File: rtl/seq_div4.sv
// Sequential restoring divider: one quotient bit per clock, MSB first, W+1 cycles per result.
// Define DIVZERO_DETECT_EN to short-circuit a zero divisor straight to DONE with o_dz set.
module seq_div4 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [W-1:0] i_dividend,
  input  logic [W-1:0] i_divisor,
  output logic [W-1:0] o_quotient,
  output logic [W-1:0] o_remainder,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_dz
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [W:0]    r_rem;
  logic [W-1:0]  r_quo;
  logic [W-1:0]  r_div;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_quotient;
  logic [W-1:0]  r_remainder;
  logic          r_busy;
  logic          r_done;

  logic [W:0]    w_shift;
  logic [W:0]    w_ndiv;
  logic [W:0]    w_diff;
  logic [W:0]    w_rem_nx;
  logic          w_carry;
  logic [W-1:0]  w_quo_nx;
  logic          w_zero_skip;

  // r_quo starts as the dividend; its MSB feeds the remainder while quotient bits enter at the LSB.
  assign w_shift  = (r_rem << 1) | {{W{1'b0}}, r_quo[W-1]};
  assign w_ndiv   = ~{1'b0, r_div};
  assign {w_carry, w_diff} = {1'b0, w_shift} + {1'b0, w_ndiv} + {{(W+1){1'b0}}, 1'b1};
  assign w_rem_nx = w_carry ? w_diff : w_shift;
  assign w_quo_nx = {r_quo[W-2:0], w_carry};

`ifdef DIVZERO_DETECT_EN
  logic r_dz;
  logic w_accept;

  assign w_zero_skip = (i_divisor == '0);
  assign w_accept    = i_start && (r_state != S_RUN);
  assign o_dz        = r_dz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dz <= 1'b0;
    end else if (w_accept) begin
      r_dz <= w_zero_skip;
    end
  end
`else
  assign w_zero_skip = 1'b0;
  assign o_dz        = 1'b0;
`endif

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_quo       <= '0;
      r_div       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            if (w_zero_skip) begin
              r_state     <= S_DONE;
              r_done      <= 1'b1;
              r_quotient  <= '1;
              r_remainder <= i_dividend;
            end else begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
              r_rem   <= '0;
              r_quo   <= i_dividend;
              r_div   <= i_divisor;
              r_cnt   <= CW'(W - 1);
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_nx;
          r_quo <= w_quo_nx;
          if (r_cnt == '0) begin
            r_state     <= S_DONE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_quotient  <= w_quo_nx;
            r_remainder <= w_rem_nx[W-1:0];
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_quotient  = r_quotient;
  assign o_remainder = r_remainder;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/seq_div4.md
SEQ_DIV4 -- requirements
Module: seq_div4

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand width in bits; legal values are 2 to 8.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  request a division; sampled only in IDLE or DONE.
REQ-005 dividend  input  W  unsigned dividend; captured on the start edge.
REQ-006 divisor  input  W  unsigned divisor; captured on the start edge.
REQ-007 quotient  output  W  unsigned quotient; registered.
REQ-008 remainder  output  W  unsigned remainder; registered.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; results valid from this cycle.
REQ-011 dz  output  1  divide-by-zero flag; registered.

Function
REQ-012 Algorithm SHALL be restoring division, one quotient bit per clock, MSB first.
REQ-013 Each iteration:
- shift the (W+1)-bit partial remainder left and bring in the next dividend bit;
- subtract the divisor as add of inverted divisor with carry-in 1, at W+1 bits;
- carry-out 1: keep the difference and set the quotient bit to 1;
- carry-out 0: restore the previous value and set the quotient bit to 0.
REQ-014 FSM states: IDLE, RUN, DONE.
- IDLE->RUN on start=1.
- RUN->DONE after exactly W iterations.
- DONE->IDLE after one cycle when start=0.
- DONE->RUN when start=1.
REQ-015 Latency: start sampled at edge k -> busy=1 in cycles k+1..k+W, done=1 in cycle k+W+1 only.
REQ-016 Capture: operands SHALL be captured on the start edge; later operand changes SHALL NOT affect the result.
REQ-017 start=1 while busy SHALL be ignored, with no restart and no result corruption.
REQ-018 quotient and remainder SHALL hold their last values until the next done.
REQ-019 Invariant: dividend = quotient*divisor + remainder and remainder < divisor, for every divisor != 0.
REQ-020 Back-to-back: start held high continuously SHALL produce one result every W+1 cycles.

Reset
REQ-021 rst_n=0 SHALL immediately force state=IDLE and quotient, remainder, busy, done, dz to 0, with no clock required.
REQ-022 Reset during RUN SHALL abandon the operation; no done SHALL follow reset release.
REQ-023 The first start SHALL be accepted on the first rising edge after rst_n rises.

Configuration
REQ-024 Macro DIVZERO_DETECT_EN.
- Defined: divisor=0 at start SHALL skip RUN (IDLE->DONE), give done at k+1, dz=1, quotient all ones, remainder=dividend.
- Not defined: dz SHALL be tied 0, and divisor 0 SHALL run the normal W iterations, giving quotient all ones and remainder=dividend with standard latency.
- dz SHALL clear on the next accepted start.

Verification
REQ-025 W=4, 13/3 -> done at k+5, quotient=4, remainder=1, busy high for exactly 4 cycles.
REQ-026 7/9 -> quotient=0, remainder=7; 15/1 -> quotient=15, remainder=0.
REQ-027 Divisor 0, dividend 11:
- macro on: done at k+1, dz=1, quotient=15, remainder=11;
- macro off: done at k+5, dz=0, same quotient and remainder.
REQ-028 Start 12/5, pulse start with 9/2 at k+2 -> single done at k+5 with quotient=2, remainder=2.
REQ-029 Start 14/4, assert rst_n=0 at k+2 for 1 cycle -> all outputs 0 at once, no done for 10 cycles, then 14/4 -> quotient=3, remainder=2.
REQ-030 Exhaustive sweep, all 256 W=4 operand pairs back-to-back -> every result matches REQ-019, and dz per REQ-024.
